// File: rtl/sm_addsub_seq.sv
// Sign-magnitude add/subtract on one shared adder. Sequence: convert A, convert B, add, convert result back.
// Latency: start accepted at edge k, done pulses k+4..k+5. No backpressure: start is ignored while busy.
module sm_addsub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int MW = WIDTH - 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {MW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_A,
    S_CONV_B,
    S_ADD,
    S_CONV_R,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] opa, opb, sum_q, res_q;
  logic             add_ovf_q, ovf_q;

  logic [WIDTH-1:0] conv_in, add_x, add_y, adder_sum;
  logic             conv_sign, add_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CONV_A;
      end
      S_CONV_A: state_nxt = S_CONV_B;
      S_CONV_B: state_nxt = S_ADD;
      S_ADD:    state_nxt = S_CONV_R;
      S_CONV_R: state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand mux for the single adder; a zero magnitude never takes the negate path.
  always_comb begin
    conv_in   = '0;
    conv_sign = 1'b0;
    case (state)
      S_CONV_A: begin
        conv_in   = {1'b0, opa[MW-1:0]};
        conv_sign = opa[WIDTH-1] & (|opa[MW-1:0]);
      end
      S_CONV_B: begin
        conv_in   = {1'b0, opb[MW-1:0]};
        conv_sign = opb[WIDTH-1] & (|opb[MW-1:0]);
      end
      S_CONV_R: begin
        conv_in   = sum_q;
        conv_sign = sum_q[WIDTH-1];
      end
      default: begin
        conv_in   = '0;
        conv_sign = 1'b0;
      end
    endcase

    add_x   = conv_in ^ {WIDTH{conv_sign}};
    add_y   = '0;
    add_cin = conv_sign;
    if (state == S_ADD) begin
      add_x   = opa;
      add_y   = opb;
      add_cin = 1'b0;
    end
  end

  assign adder_sum = add_x + add_y + {{MW{1'b0}}, add_cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      sum_q     <= '0;
      add_ovf_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa <= a;
            opb <= {b[WIDTH-1] ^ op, b[MW-1:0]};
          end
        end
        S_CONV_A: opa <= adder_sum;
        S_CONV_B: opb <= adder_sum;
        S_ADD: begin
          sum_q     <= adder_sum;
          add_ovf_q <= (opa[WIDTH-1] == opb[WIDTH-1]) &&
                       (adder_sum[WIDTH-1] != opa[WIDTH-1]);
        end
        S_CONV_R: begin
          // The most negative sum has no positive magnitude, so it saturates too.
          if (add_ovf_q || (sum_q == MIN_NEG)) begin
            res_q <= {opa[WIDTH-1], {MW{1'b1}}};
            ovf_q <= 1'b1;
          end else begin
            res_q <= {sum_q[WIDTH-1], adder_sum[MW-1:0]};
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign result   = res_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sm_addsub_seq.sv
// Directed bench for sm_addsub_seq: arithmetic vectors, saturation, handshake timing and async reset.
module tb_sm_addsub_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, overflow;
  logic [7:0] result;

  int n_chk = 0;
  int n_bad = 0;

  sm_addsub_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation from start; checks busy/done every cycle and result/overflow on done.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic top, input logic [7:0] exp_res, input logic exp_ovf);
    @(negedge clk);
    a = ta; b = tb; op = top; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'(i < 5));
      check({tag, "_done"}, 32'(done), 32'(i == 4));
      if (i == 4) begin
        check({tag, "_res"}, 32'(result), 32'(exp_res));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      end
    end
  endtask

  initial begin
    int ndone;
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", 32'(result), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add53",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0);
    run_op("add5m7",  8'h05, 8'h87, 1'b0, 8'h82, 1'b0);
    run_op("subm7_5", 8'h87, 8'h05, 1'b1, 8'h8C, 1'b0);
    run_op("zero_sub", 8'h83, 8'h83, 1'b1, 8'h00, 1'b0);
    run_op("negzero", 8'h80, 8'h00, 1'b0, 8'h00, 1'b0);
    run_op("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h7F, 1'b1);
    run_op("ovf_min", 8'hFF, 8'h81, 1'b0, 8'hFF, 1'b1);

    // start held for 8 edges: accepted at i=0 and again at i=6 only
    @(negedge clk);
    a = 8'h01; b = 8'h01; op = 1'b0; start = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      check("hs_done", 32'(done), 32'((i == 4) || (i == 10)));
      check("hs_busy", 32'(busy), 32'((i != 5) && (i != 11)));
      if (i == 4 || i == 10) check("hs_res", 32'(result), 32'h02);
      if (i == 0) begin a = 8'h7F; b = 8'h7F; end
      if (i == 4) begin a = 8'h01; b = 8'h01; end
      if (i == 7) start = 1'b0;
    end
    check("hs_ndone", 32'(ndone), 32'd2);

    run_op("ovf_sub", 8'h40, 8'hC0, 1'b1, 8'h7F, 1'b1);

    // reset while in ADD: outputs clear without a clock edge
    @(negedge clk);
    a = 8'h05; b = 8'h03; op = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_busy", 32'(busy), 32'd1);
    check("pre_res", 32'(result), 32'h7F);
    check("pre_ovf", 32'(overflow), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_res", 32'(result), 32'd0);
    check("mid_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
